// File: rtl/frac_baud_pkg.sv
// Shared types and constants for the fractional baud generator.
// Divisors are unsigned fixed point: integer clocks per oversample tick plus a binary fraction.
package frac_baud_pkg;

    localparam int MIN_DIV_INT   = 2;
    localparam int DEF_DIV_W     = 16;
    localparam int DEF_FRAC_BITS = 4;

    typedef struct packed {
        logic [DEF_DIV_W-1:0]     div_int;
        logic [DEF_FRAC_BITS-1:0] div_frac;
    } baud_div_t;

    // Rounded fixed-point divisor; 50 MHz / 115200 gives 6944 (434.0 clocks per oversample tick).
    function automatic logic [63:0] default_divisor(input logic [63:0] clk_frq,
                                                    input logic [63:0] baud_rate,
                                                    input int          frac_bits);
        logic [63:0] num;
        num = clk_frq << frac_bits;
        return (num + (baud_rate >> 1)) / baud_rate;
    endfunction

endpackage

// File: rtl/frac_tick_divider.sv
// Fractional clock divider: periods of div_int or div_int+1 clocks, one-clock tick on the last.
// The carry out of the fraction accumulator decides which length the current period gets.
module frac_tick_divider
    import frac_baud_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int FRAC_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DIV_W+FRAC_BITS-1:0] divisor,
    input  logic                       enable,
    input  logic                       restart,
    output logic                       tick
);

    localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);

    logic [DIV_W:0]     r_cnt;
    logic [FRAC_BITS-1:0] r_acc;
    logic [FRAC_BITS:0] w_sum;
    logic [DIV_W:0]     w_len;

    assign w_sum = {1'b0, r_acc} + {1'b0, divisor[FRAC_BITS-1:0]};
    assign w_len = {1'b0, divisor[DIV_W+FRAC_BITS-1:FRAC_BITS]} + {{DIV_W{1'b0}}, w_sum[FRAC_BITS]};

    // Divisors below 2 clocks never reach here, so a zero count is never a last clock.
    assign tick = enable && !restart && (r_cnt >= w_len - CNT_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (!enable || restart) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (tick) begin
            r_cnt <= '0;
            r_acc <= w_sum[FRAC_BITS-1:0];
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/frac_baud_generator.sv
// Oversampling baud tick generator with a fractional divisor and glitch-free divisor updates.
// New divisors wait in a one-deep pending slot until a baud boundary, a resync, or idle.
module frac_baud_generator
    import frac_baud_pkg::*;
#(
    parameter int unsigned CLK_FRQ    = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int          DIV_W      = 16,
    parameter int          FRAC_BITS  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             resync,
    input  logic                             cfg_valid,
    input  logic [DIV_W+FRAC_BITS-1:0]       cfg_div,
    output logic                             cfg_ready,
    output logic                             cfg_err,
    output logic [DIV_W+FRAC_BITS-1:0]       active_div,
    output logic                             os_tick,
    output logic                             baud_tick,
    output logic                             baud_clk,
    output logic [$clog2(OVERSAMPLE)-1:0]    os_phase
);

    localparam int DW   = DIV_W + FRAC_BITS;
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0]   DEF_DIV    = DW'(default_divisor(64'(CLK_FRQ), 64'(BAUD_RATE), FRAC_BITS));
    localparam logic [OS_W-1:0] PHASE_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DW-1:0]   r_active_div;
    logic [DW-1:0]   r_pend_div;
    logic            r_pending;
    logic            r_cfg_err;
    logic [OS_W-1:0] r_os_phase;

    logic w_tick;
    logic w_baud_tick;
    logic w_accept;
    logic w_div_legal;
    logic w_apply;

    frac_tick_divider #(
        .DIV_W     (DIV_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .divisor (r_active_div),
        .enable  (enable),
        .restart (resync),
        .tick    (w_tick)
    );

    assign w_accept    = cfg_valid && !r_pending;
    assign w_div_legal = cfg_div[DW-1:FRAC_BITS] >= DIV_W'(MIN_DIV_INT);
    assign w_baud_tick = w_tick && (r_os_phase == PHASE_LAST);
    assign w_apply     = r_pending && (w_baud_tick || resync || !enable);

    // Illegal divisors are consumed without occupying the pending slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active_div <= DEF_DIV;
            r_pend_div   <= '0;
            r_pending    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_div_legal;
            if (w_apply) begin
                r_active_div <= r_pend_div;
                r_pending    <= 1'b0;
            end else if (w_accept && w_div_legal) begin
                r_pend_div <= cfg_div;
                r_pending  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_os_phase <= '0;
        end else if (!enable || resync) begin
            r_os_phase <= '0;
        end else if (w_tick) begin
            r_os_phase <= r_os_phase + OS_W'(1);
        end
    end

    assign cfg_ready  = !r_pending;
    assign cfg_err    = r_cfg_err;
    assign active_div = r_active_div;
    assign os_tick    = w_tick;
    assign baud_tick  = w_baud_tick;
    assign baud_clk   = r_os_phase[OS_W-1];
    assign os_phase   = r_os_phase;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Bench for frac_baud_generator: table of divisors with expected tick intervals, plus
// hand sequences for deferred config, illegal divisors, resync and asynchronous reset.
module tb_frac_baud_generator;
    import frac_baud_pkg::*;

    localparam int FB = 4;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          resync;
    logic          cfg_valid;
    logic [DW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;
    logic [DW-1:0] active_div;
    logic          os_tick;
    logic          baud_tick;
    logic          baud_clk;
    logic [3:0]    os_phase;

    frac_baud_generator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .resync     (resync),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .active_div (active_div),
        .os_tick    (os_tick),
        .baud_tick  (baud_tick),
        .baud_clk   (baud_clk),
        .os_phase   (os_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        baud_div_t div;
        int        n;
        int        exp_total;
        int        exp_hi;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_q[$];
    int          total_n = 0;
    int          bad_n   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic baud_div_t mk_div(input int ip, input int fp);
        baud_div_t d;
        d.div_int  = 16'(ip);
        d.div_frac = 4'(fp);
        return d;
    endfunction

    // Exact-arithmetic length of period k: cumulative ideal time rounded down, differenced.
    function automatic int seg_len(input int d, input int k);
        return (((k + 1) * d) >> FB) - ((k * d) >> FB);
    endfunction

    task automatic wait_tick(input int budget, output int cyc, output int hi);
        bit found;
        found = 1'b0;
        cyc   = 0;
        hi    = 0;
        while (!found && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (baud_clk) hi++;
            if (os_tick) found = 1'b1;
        end
        check("tick_seen", 32'(found), 32'd1);
    endtask

    task automatic expect_tick(input string name, input int exp_len, input int budget);
        int cyc;
        int hi;
        exp_q.push_back(32'(exp_len));
        wait_tick(budget, cyc, hi);
        if (exp_q.size() == 0) check("queue_empty", 32'd0, 32'd1);
        else check(name, 32'(cyc), exp_q.pop_front());
    endtask

    task automatic apply_cfg(input baud_div_t d);
        step();
        enable    = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = d;
        step();
        cfg_valid = 1'b0;
        check("cfg_ready_pending", 32'(cfg_ready), 32'd0);
        step();
        check("active_div_applied", 32'(active_div), 32'(d));
        check("cfg_ready_free", 32'(cfg_ready), 32'd1);
    endtask

    task automatic run_vector(input vec_t v);
        int d;
        int cyc;
        int hi;
        int tot;
        int hi_tot;
        d = int'(v.div);
        apply_cfg(v.div);
        for (int k = 0; k < v.n; k++) exp_q.push_back(32'(seg_len(d, k)));
        enable = 1'b1;
        tot    = 0;
        hi_tot = 0;
        for (int k = 0; k < v.n; k++) begin
            wait_tick((d >> FB) + 3, cyc, hi);
            tot    += cyc;
            hi_tot += hi;
            if (exp_q.size() == 0) check("queue_empty", 32'd0, 32'd1);
            else check("interval", 32'(cyc), exp_q.pop_front());
            check("phase_at_tick", 32'(os_phase), 32'(k % 16));
            check("baud_tick", 32'(baud_tick), 32'(k % 16 == 15));
        end
        check("total_clks", 32'(tot), 32'(v.exp_total));
        check("baud_clk_high", 32'(hi_tot), 32'(v.exp_hi));
        step();
        check("phase_wrapped", 32'(os_phase), 32'(v.n % 16));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_os_tick"}, 32'(os_tick), 32'd0);
        check({tag, "_baud_tick"}, 32'(baud_tick), 32'd0);
        check({tag, "_baud_clk"}, 32'(baud_clk), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_os_phase"}, 32'(os_phase), 32'd0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_active_div"}, 32'(active_div), 32'd6944);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{div: mk_div(434, 0),  n: 16, exp_total: 6944, exp_hi: 3472};
        vecs[1] = '{div: mk_div(10, 8),   n: 16, exp_total: 168,  exp_hi: 84};
        vecs[2] = '{div: mk_div(2, 0),    n: 16, exp_total: 32,   exp_hi: 16};
        vecs[3] = '{div: mk_div(3, 4),    n: 16, exp_total: 52,   exp_hi: 26};
        vecs[4] = '{div: mk_div(5, 15),   n: 16, exp_total: 95,   exp_hi: 48};
        vecs[5] = '{div: mk_div(2, 1),    n: 16, exp_total: 33,   exp_hi: 17};
        vecs[6] = '{div: mk_div(7, 12),   n: 16, exp_total: 124,  exp_hi: 62};

        reset_n   = 1'b0;
        enable    = 1'b0;
        resync    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        #23;
        check_reset_outputs("reset");
        step();
        reset_n = 1'b1;
        step();
        check_reset_outputs("post_reset");

        // Illegal divisors: error pulse one clock after accept, nothing else moves.
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1;
            cfg_div   = (i == 0) ? mk_div(1, 8) : mk_div(0, 15);
            check("bad_cfg_ready_before", 32'(cfg_ready), 32'd1);
            step();
            cfg_valid = 1'b0;
            check("bad_cfg_err_pulse", 32'(cfg_err), 32'd1);
            check("bad_cfg_ready_after", 32'(cfg_ready), 32'd1);
            check("bad_cfg_active_div", 32'(active_div), 32'd6944);
            step();
            check("bad_cfg_err_clear", 32'(cfg_err), 32'd0);
            check("bad_cfg_active_div2", 32'(active_div), 32'd6944);
            check("bad_cfg_ready_later", 32'(cfg_ready), 32'd1);
        end

        for (int i = 0; i < 7; i++) run_vector(vecs[i]);

        // Divisor accepted mid-baud at phase 5 waits for the baud tick.
        apply_cfg(mk_div(10, 0));
        enable = 1'b1;
        for (int k = 0; k < 5; k++) expect_tick("pre_cfg_interval", 10, 13);
        step();
        check("phase_at_cfg", 32'(os_phase), 32'd5);
        cfg_valid = 1'b1;
        cfg_div   = mk_div(12, 0);
        step();
        cfg_valid = 1'b0;
        check("deferred_ready_low", 32'(cfg_ready), 32'd0);
        for (int k = 0; k < 11; k++) begin
            expect_tick("deferred_interval", (k == 0) ? 9 : 10, 13);
            check("deferred_still_pending", 32'(cfg_ready), 32'd0);
            check("deferred_old_div", 32'(active_div), 32'(mk_div(10, 0)));
            check("deferred_baud_tick", 32'(baud_tick), 32'(k == 10));
        end
        step();
        check("deferred_applied", 32'(active_div), 32'(mk_div(12, 0)));
        check("deferred_ready_high", 32'(cfg_ready), 32'd1);
        check("deferred_phase0", 32'(os_phase), 32'd0);
        expect_tick("deferred_new_period", 12, 15);
        step();
        enable = 1'b0;
        step();
        check("disabled_phase", 32'(os_phase), 32'd0);
        check("disabled_tick", 32'(os_tick), 32'd0);

        // Resync lands on the clock where the phase-7 tick is due; it also applies a pending divisor.
        apply_cfg(mk_div(10, 0));
        enable = 1'b1;
        for (int k = 0; k < 7; k++) expect_tick("pre_resync_interval", 10, 13);
        step();
        cfg_valid = 1'b1;
        cfg_div   = mk_div(12, 0);
        step();
        cfg_valid = 1'b0;
        check("resync_pending", 32'(cfg_ready), 32'd0);
        repeat (8) step();
        resync = 1'b1;
        @(negedge clk);
        check("resync_no_tick", 32'(os_tick), 32'd0);
        check("resync_no_baud", 32'(baud_tick), 32'd0);
        check("resync_phase_before", 32'(os_phase), 32'd7);
        step();
        resync = 1'b0;
        check("resync_phase_zero", 32'(os_phase), 32'd0);
        check("resync_applied_div", 32'(active_div), 32'(mk_div(12, 0)));
        check("resync_ready", 32'(cfg_ready), 32'd1);
        expect_tick("resync_next_tick", 12, 15);

        // Asynchronous reset mid-period with a configuration pending.
        step();
        cfg_valid = 1'b1;
        cfg_div   = mk_div(10, 0);
        step();
        cfg_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (os_phase != 4'd9 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            check("reach_phase9", 32'(os_phase), 32'd9);
        end
        check("pre_reset_baud_clk", 32'(baud_clk), 32'd1);
        check("pre_reset_pending", 32'(cfg_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        reset_n = 1'b1;
        expect_tick("after_reset_period", 434, 440);
        check("after_reset_div", 32'(active_div), 32'd6944);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
